// File: rtl/c3_heap_pkg.sv
// Shared definitions for the C3 heap custom-instruction unit and its command issuer.
package c3_heap_pkg;

  localparam int HEAP_SIZE      = 11;
  localparam int HEAP_IDX_WIDTH = 4;
  localparam int CMD_WIDTH      = 38;

  localparam logic [4:0] HEAP_OP_PUSH = 5'd0;
  localparam logic [4:0] HEAP_OP_POP  = 5'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } issuer_state_t;

  typedef struct packed {
    logic        op;
    logic [4:0]  tag;
    logic [31:0] data;
  } heap_cmd_t;

endpackage

// File: rtl/c3_cmd_fifo.sv
// Synchronous FIFO for queued heap commands; DEPTH must be a power of 2 so the pointers wrap for free.
module c3_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];
  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/c3_heap_cmd_issuer.sv
// Queues push/pop requests and feeds them one at a time to the C3 heap unit,
// filtering overflow/underflow with a shadow count and returning one tagged response each.
module c3_heap_cmd_issuer
  import c3_heap_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int HEAP_SIZE = c3_heap_pkg::HEAP_SIZE,
  parameter int TIMEOUT   = 64,
  localparam int TW       = $clog2(TIMEOUT + 1),
  localparam int FW       = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_v,
  output logic                      in_ready,
  input  logic                      in_op,
  input  logic [31:0]               in_data,
  input  logic [4:0]                in_tag,
  output logic                      hp_v,
  output logic [4:0]                hp_rd,
  output logic [31:0]               hp_data,
  input  logic                      hp_idle,
  input  logic                      hp_out_v,
  input  logic [31:0]               hp_out_data,
  output logic                      resp_v,
  output logic [4:0]                resp_tag,
  output logic [31:0]               resp_data,
  output logic                      resp_err,
  output logic [HEAP_IDX_WIDTH-1:0] heap_count,
  output logic [FW-1:0]             fifo_count
);

  localparam logic [HEAP_IDX_WIDTH-1:0] HEAP_FULL = HEAP_IDX_WIDTH'(HEAP_SIZE);

  issuer_state_t             state_r, state_n;
  heap_cmd_t                 head_s;
  heap_cmd_t                 wr_cmd_s;
  logic [CMD_WIDTH-1:0]      head_bits_s;
  logic                      fifo_full_s, fifo_empty_s, deq_s;
  logic                      hp_v_r, hp_v_n;
  logic [4:0]                hp_rd_r, hp_rd_n;
  logic [31:0]               hp_data_r, hp_data_n;
  logic                      resp_v_r, resp_v_n;
  logic [4:0]                resp_tag_r, resp_tag_n;
  logic [31:0]               resp_data_r, resp_data_n;
  logic                      resp_err_r, resp_err_n;
  logic [HEAP_IDX_WIDTH-1:0] heap_count_r, heap_count_n;
  logic [TW-1:0]             timer_r, timer_n;
  logic                      cur_op_r, cur_op_n;
  logic [4:0]                cur_tag_r, cur_tag_n;
  logic                      cap_v_r, cap_v_n;
  logic [31:0]               cap_data_r, cap_data_n;
  logic                      data_ok_s;

  assign wr_cmd_s = '{op: in_op, tag: in_tag, data: in_data};
  assign head_s   = heap_cmd_t'(head_bits_s);
  assign in_ready = !fifo_full_s;

  c3_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_WIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_v),
    .wr_data (wr_cmd_s),
    .rd_en   (deq_s),
    .rd_data (head_bits_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  assign hp_v       = hp_v_r;
  assign hp_rd      = hp_rd_r;
  assign hp_data    = hp_data_r;
  assign resp_v     = resp_v_r;
  assign resp_tag   = resp_tag_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;
  assign heap_count = heap_count_r;

  // Pop data may arrive in the same cycle the heap returns idle.
  assign data_ok_s = cap_v_r || hp_out_v;

  // Next-state and next-output logic; strobes are registered so they rise in the target state.
  always_comb begin
    state_n      = state_r;
    deq_s        = 1'b0;
    hp_v_n       = 1'b0;
    hp_rd_n      = hp_rd_r;
    hp_data_n    = hp_data_r;
    resp_v_n     = 1'b0;
    resp_tag_n   = resp_tag_r;
    resp_data_n  = resp_data_r;
    resp_err_n   = resp_err_r;
    heap_count_n = heap_count_r;
    timer_n      = timer_r;
    cur_op_n     = cur_op_r;
    cur_tag_n    = cur_tag_r;
    cap_v_n      = cap_v_r;
    cap_data_n   = cap_data_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && hp_idle) begin
          state_n = ST_CHECK;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if ((!head_s.op && heap_count_r == HEAP_FULL) ||
            (head_s.op && heap_count_r == '0)) begin
          deq_s       = 1'b1;
          resp_v_n    = 1'b1;
          resp_tag_n  = head_s.tag;
          resp_data_n = 32'd0;
          resp_err_n  = 1'b1;
          state_n     = ST_RESP;
        end else begin
          hp_v_n    = 1'b1;
          hp_rd_n   = head_s.op ? HEAP_OP_POP : HEAP_OP_PUSH;
          hp_data_n = head_s.data;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        deq_s      = 1'b1;
        cur_op_n   = head_s.op;
        cur_tag_n  = head_s.tag;
        cap_v_n    = 1'b0;
        cap_data_n = 32'd0;
        timer_n    = '0;
        if (head_s.op) begin
          heap_count_n = heap_count_r - HEAP_IDX_WIDTH'(1);
        end else begin
          heap_count_n = heap_count_r + HEAP_IDX_WIDTH'(1);
        end
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (cur_op_r && hp_out_v && !cap_v_r) begin
          cap_v_n    = 1'b1;
          cap_data_n = hp_out_data;
        end else begin
          cap_v_n    = cap_v_r;
        end
        // timer_r == 0 marks the guard cycle while the heap is still leaving IDLE.
        if (timer_r != '0 && hp_idle && (!cur_op_r || data_ok_s)) begin
          resp_v_n    = 1'b1;
          resp_tag_n  = cur_tag_r;
          resp_data_n = !cur_op_r ? 32'd0 : (cap_v_r ? cap_data_r : hp_out_data);
          resp_err_n  = 1'b0;
          state_n     = ST_RESP;
        end else if (timer_r == TW'(TIMEOUT)) begin
          resp_v_n    = 1'b1;
          resp_tag_n  = cur_tag_r;
          resp_data_n = 32'd0;
          resp_err_n  = 1'b1;
          state_n     = ST_RESP;
        end else begin
          timer_n = timer_r + TW'(1);
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      hp_v_r       <= 1'b0;
      hp_rd_r      <= 5'd0;
      hp_data_r    <= 32'd0;
      resp_v_r     <= 1'b0;
      resp_tag_r   <= 5'd0;
      resp_data_r  <= 32'd0;
      resp_err_r   <= 1'b0;
      heap_count_r <= '0;
      timer_r      <= '0;
      cur_op_r     <= 1'b0;
      cur_tag_r    <= 5'd0;
      cap_v_r      <= 1'b0;
      cap_data_r   <= 32'd0;
    end else begin
      state_r      <= state_n;
      hp_v_r       <= hp_v_n;
      hp_rd_r      <= hp_rd_n;
      hp_data_r    <= hp_data_n;
      resp_v_r     <= resp_v_n;
      resp_tag_r   <= resp_tag_n;
      resp_data_r  <= resp_data_n;
      resp_err_r   <= resp_err_n;
      heap_count_r <= heap_count_n;
      timer_r      <= timer_n;
      cur_op_r     <= cur_op_n;
      cur_tag_r    <= cur_tag_n;
      cap_v_r      <= cap_v_n;
      cap_data_r   <= cap_data_n;
    end
  end

endmodule

// File: tb/tb_c3_heap_cmd_issuer.sv
// Directed bench for c3_heap_cmd_issuer with a small max-heap responder model.
module tb_c3_heap_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v, in_ready, in_op;
  logic [31:0] in_data;
  logic [4:0]  in_tag;
  logic        hp_v;
  logic [4:0]  hp_rd;
  logic [31:0] hp_data;
  logic        hp_idle;
  logic        hp_out_v;
  logic [31:0] hp_out_data;
  logic        resp_v;
  logic [4:0]  resp_tag;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [3:0]  heap_count;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;
  int stall = 0;
  logic hang = 1'b0;

  logic [31:0] hv [16];
  int          hlen;
  int          busy;
  logic        pend;

  logic [4:0]  hp_rd_q[$];
  logic [31:0] hp_data_q[$];
  logic [4:0]  r_tag_q[$];
  logic [31:0] r_data_q[$];
  logic        r_err_q[$];

  c3_heap_cmd_issuer dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_ready(in_ready), .in_op(in_op), .in_data(in_data), .in_tag(in_tag),
    .hp_v(hp_v), .hp_rd(hp_rd), .hp_data(hp_data),
    .hp_idle(hp_idle), .hp_out_v(hp_out_v), .hp_out_data(hp_out_data),
    .resp_v(resp_v), .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err),
    .heap_count(heap_count), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic int max_idx();
    int b = 0;
    for (int i = 1; i < hlen; i++) begin
      if (hv[i] > hv[b]) b = i;
    end
    return b;
  endfunction

  // Heap model: busy for 2+stall cycles per command, pops then return the maximum.
  always @(posedge clk) begin
    hp_out_v <= 1'b0;
    if (reset) begin
      hp_idle <= 1'b1;
      busy    <= 0;
      pend    <= 1'b0;
      hlen    <= 0;
    end else if (hp_v) begin
      hp_idle <= 1'b0;
      busy    <= 2 + stall;
      if (hp_rd == 5'd1) begin
        if (hlen > 0) begin
          hp_out_data   <= hv[max_idx()];
          hv[max_idx()] <= hv[hlen-1];
          hlen          <= hlen - 1;
        end
        pend <= 1'b1;
      end else begin
        hv[hlen] <= hp_data;
        hlen     <= hlen + 1;
      end
    end else if (!hp_idle) begin
      if (busy != 0) begin
        busy <= busy - 1;
      end else if (pend) begin
        if (!hang) begin
          hp_out_v <= 1'b1;
          pend     <= 1'b0;
        end
      end else begin
        hp_idle <= 1'b1;
      end
    end
  end

  // Record every heap command and every response.
  always @(negedge clk) begin
    if (!reset) begin
      if (hp_v) begin
        hp_rd_q.push_back(hp_rd);
        hp_data_q.push_back(hp_data);
      end
      if (resp_v) begin
        r_tag_q.push_back(resp_tag);
        r_data_q.push_back(resp_data);
        r_err_q.push_back(resp_err);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic op, input logic [31:0] d, input logic [4:0] t);
    int n = 0;
    in_v = 1'b1; in_op = op; in_data = d; in_tag = t;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    tick();
    in_v = 1'b0;
    check("send_accepted", 32'(n < 300), 32'd1);
  endtask

  task automatic wait_resp(input int n, input int budget, input string name);
    int c = 0;
    while (r_tag_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, r_tag_q.size(), n);
  endtask

  task automatic wait_hp(input int n, input int budget, input string name);
    int c = 0;
    while (hp_rd_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, hp_rd_q.size(), n);
  endtask

  initial begin
    reset = 1'b1; in_v = 1'b0; in_op = 1'b0; in_data = 32'd0; in_tag = 5'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_hp_v", hp_v, 32'd0);
    check("rst_hp_rd", hp_rd, 32'd0);
    check("rst_hp_data", hp_data, 32'd0);
    check("rst_resp_v", resp_v, 32'd0);
    check("rst_resp_tag", resp_tag, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", resp_err, 32'd0);
    check("rst_heap_count", heap_count, 32'd0);
    check("rst_fifo_count", fifo_count, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);

    // Three pushes back-to-back.
    send(1'b0, 32'd5, 5'd1);
    send(1'b0, 32'd9, 5'd2);
    send(1'b0, 32'd3, 5'd3);
    wait_resp(3, 200, "push3_resp_cnt");
    check("push3_hp_cnt", hp_rd_q.size(), 32'd3);
    check("push3_rd0", hp_rd_q[0], 32'd0);
    check("push3_rd2", hp_rd_q[2], 32'd0);
    check("push3_d0", hp_data_q[0], 32'd5);
    check("push3_d1", hp_data_q[1], 32'd9);
    check("push3_d2", hp_data_q[2], 32'd3);
    check("push3_err0", r_err_q[0], 32'd0);
    check("push3_err2", r_err_q[2], 32'd0);
    check("push3_tag1", r_tag_q[1], 32'd2);
    check("push3_count", heap_count, 32'd3);

    // Pop returns the maximum.
    send(1'b1, 32'd0, 5'd7);
    wait_resp(4, 200, "pop_resp_cnt");
    check("pop_rd", hp_rd_q[3], 32'd1);
    check("pop_tag", r_tag_q[3], 32'd7);
    check("pop_data", r_data_q[3], 32'd9);
    check("pop_err", r_err_q[3], 32'd0);
    check("pop_count", heap_count, 32'd2);

    // Drain, then pop on an empty heap.
    send(1'b1, 32'd0, 5'd8);
    send(1'b1, 32'd0, 5'd9);
    wait_resp(6, 300, "drain_resp_cnt");
    check("drain_d4", r_data_q[4], 32'd5);
    check("drain_d5", r_data_q[5], 32'd3);
    send(1'b1, 32'd0, 5'd4);
    wait_resp(7, 200, "empty_resp_cnt");
    check("empty_no_hp_v", hp_rd_q.size(), 32'd6);
    check("empty_tag", r_tag_q[6], 32'd4);
    check("empty_err", r_err_q[6], 32'd1);
    check("empty_data", r_data_q[6], 32'd0);
    check("empty_count", heap_count, 32'd0);

    // Fill to capacity, then one push too many.
    for (int i = 1; i <= 12; i++) send(1'b0, 32'(i), 5'(10 + i));
    wait_resp(19, 1000, "fill_resp_cnt");
    check("fill_hp_cnt", hp_rd_q.size(), 32'd17);
    check("fill_11th_err", r_err_q[17], 32'd0);
    check("full_tag", r_tag_q[18], 32'd22);
    check("full_err", r_err_q[18], 32'd1);
    check("full_count", heap_count, 32'd11);

    // Stalled heap: queue fills behind the in-flight pop.
    stall = 8;
    send(1'b1, 32'd0, 5'd20);
    wait_hp(18, 100, "stall_issue");
    for (int i = 21; i <= 24; i++) send(1'b1, 32'd0, 5'(i));
    check("stall_fifo_count", fifo_count, 32'd4);
    check("stall_in_ready", in_ready, 32'd0);
    check("stall_hp_idle", hp_idle, 32'd0);
    check("stall_no_hp_v", hp_rd_q.size(), 32'd18);
    wait_resp(24, 400, "stall_resp_cnt");
    for (int i = 0; i < 5; i++) begin
      check("stall_tag", r_tag_q[19+i], 32'(20 + i));
      check("stall_data", r_data_q[19+i], 32'(11 - i));
      check("stall_err", r_err_q[19+i], 32'd0);
    end
    check("stall_count", heap_count, 32'd6);
    stall = 0;

    // Heap never answers a pop: timeout error, count not rolled back.
    hang = 1'b1;
    send(1'b1, 32'd0, 5'd25);
    wait_resp(25, 300, "timeout_resp_cnt");
    check("timeout_tag", r_tag_q[24], 32'd25);
    check("timeout_err", r_err_q[24], 32'd1);
    check("timeout_data", r_data_q[24], 32'd0);
    check("timeout_count", heap_count, 32'd5);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    hang = 1'b0;
    tick();
    send(1'b0, 32'd77, 5'd26);
    wait_resp(26, 200, "post_rst_resp_cnt");
    check("post_rst_err", r_err_q[25], 32'd0);
    check("post_rst_count", heap_count, 32'd1);

    // Reset in the middle of WAIT discards in-flight and queued work.
    hang = 1'b1;
    send(1'b1, 32'd0, 5'd27);
    wait_hp(25, 100, "midwait_issue");
    repeat (10) tick();
    send(1'b0, 32'd55, 5'd28);
    check("midwait_fifo", fifo_count, 32'd1);
    reset = 1'b1;
    tick();
    check("mrst_hp_v", hp_v, 32'd0);
    check("mrst_hp_rd", hp_rd, 32'd0);
    check("mrst_hp_data", hp_data, 32'd0);
    check("mrst_resp_v", resp_v, 32'd0);
    check("mrst_resp_tag", resp_tag, 32'd0);
    check("mrst_resp_data", resp_data, 32'd0);
    check("mrst_resp_err", resp_err, 32'd0);
    check("mrst_heap_count", heap_count, 32'd0);
    check("mrst_fifo_count", fifo_count, 32'd0);
    reset = 1'b0;
    hang = 1'b0;
    repeat (10) tick();
    check("mrst_no_resp", r_tag_q.size(), 32'd26);
    check("mrst_no_issue", hp_rd_q.size(), 32'd25);
    check("mrst_in_ready", in_ready, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
